// File: rtl/uart_tx_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// State encoding, pointer width and byte width.
package uart_tx_arb_pkg;

  localparam int UART_DATA_LENGTH = 8;
  localparam int UART_ARB_PTR_W   = 3;

  typedef enum logic [2:0] {
    UART_ARB_IDLE      = 3'd0,
    UART_ARB_ISSUE     = 3'd1,
    UART_ARB_WAIT_BUSY = 3'd2,
    UART_ARB_WAIT_DONE = 3'd3,
    UART_ARB_GAP       = 3'd4
  } arb_state_e;

  function automatic logic [UART_ARB_PTR_W-1:0] ptr_inc(
    input logic [UART_ARB_PTR_W-1:0] p,
    input int                        n
  );
    return (int'(p) == n - 1) ? '0 : p + 1'b1;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: scans upward from ptr,
// or offers only the owner while a packet holds the lock.
module uart_rr_pick
  import uart_tx_arb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]          req,
  input  logic [UART_ARB_PTR_W-1:0] ptr,
  input  logic                      lock,
  input  logic [UART_ARB_PTR_W-1:0] owner,
  output logic                      found,
  output logic [UART_ARB_PTR_W-1:0] winner
);

  localparam int PW = UART_ARB_PTR_W;

  logic [7:0] req_ext;

  assign req_ext = 8'(req);

  always_comb begin
    int            tmp;
    logic [PW-1:0] idx;
    found  = 1'b0;
    winner = '0;
    tmp    = 0;
    idx    = '0;
    if (lock) begin
      found  = req_ext[owner];
      winner = owner;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        tmp = int'(ptr) + i;
        if (tmp >= N_REQ) tmp = tmp - N_REQ;
        idx = PW'(tmp);
        if (!found && req_ext[idx]) begin
          found  = 1'b1;
          winner = idx;
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin sequencer sharing one uart_tx byte port among
// N_REQ requesters, one byte per frame, packets never interleave.
module uart_tx_arb
  import uart_tx_arb_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int GAP_CYCLES   = 2,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [N_REQ*UART_DATA_LENGTH-1:0]   req_data_i,
  input  logic [N_REQ-1:0]                    req_last_i,
  input  logic [N_REQ-1:0]                    req_v_i,
  output logic [N_REQ-1:0]                    req_ack_o,
  output logic [UART_DATA_LENGTH-1:0]         tx_data_o,
  output logic                                tx_v_o,
  input  logic                                uart_busy_i,
  output logic [N_REQ-1:0]                    grant_o,
  output logic                                busy_o,
  output logic                                err_timeout_o,
  input  logic                                clr_err_i
);

  localparam int PW    = UART_ARB_PTR_W;
  localparam int CNT_W = 16;

  arb_state_e      state;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   owner;
  logic [PW-1:0]   winner;
  logic            lock;
  logic            found;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic            hit_to;
  logic [7:0]      last_ext;
  logic [63:0]     data_ext;
  logic [N_REQ-1:0] win_oh;
  logic [N_REQ-1:0] own_oh;
  logic [N_REQ-1:0] idle_grant;

  uart_rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req    (req_v_i),
    .ptr    (ptr),
    .lock   (lock),
    .owner  (owner),
    .found  (found),
    .winner (winner)
  );

  assign last_ext   = 8'(req_last_i);
  assign data_ext   = 64'(req_data_i);
  assign win_oh     = N_REQ'(1) << winner;
  assign own_oh     = N_REQ'(1) << owner;
  assign idle_grant = lock ? own_oh : '0;
  assign cnt_nxt    = cnt + 1'b1;
  assign busy_o     = (state != UART_ARB_IDLE);

  assign hit_to = (state == UART_ARB_WAIT_BUSY) && !uart_busy_i &&
                  (cnt_nxt == CNT_W'(BUSY_TIMEOUT));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= UART_ARB_IDLE;
      ptr           <= '0;
      owner         <= '0;
      lock          <= 1'b0;
      cnt           <= '0;
      tx_data_o     <= '0;
      tx_v_o        <= 1'b0;
      req_ack_o     <= '0;
      grant_o       <= '0;
      err_timeout_o <= 1'b0;
    end else begin
      tx_v_o    <= 1'b0;
      req_ack_o <= '0;
      // a timeout in the same cycle as a clear keeps the flag set
      if (hit_to) err_timeout_o <= 1'b1;
      else if (clr_err_i) err_timeout_o <= 1'b0;
      unique case (state)
        UART_ARB_IDLE: begin
          if (found) begin
            tx_data_o <= data_ext[{winner, 3'b000} +: 8];
            tx_v_o    <= 1'b1;
            req_ack_o <= win_oh;
            grant_o   <= win_oh;
            owner     <= winner;
            lock      <= !last_ext[winner];
            ptr       <= ptr_inc(winner, N_REQ);
            state     <= UART_ARB_ISSUE;
          end
        end
        UART_ARB_ISSUE: begin
          cnt   <= '0;
          state <= UART_ARB_WAIT_BUSY;
        end
        UART_ARB_WAIT_BUSY: begin
          if (uart_busy_i) begin
            state <= UART_ARB_WAIT_DONE;
          end else if (hit_to) begin
            lock    <= 1'b0;
            grant_o <= '0;
            state   <= UART_ARB_IDLE;
          end else begin
            cnt <= cnt_nxt;
          end
        end
        UART_ARB_WAIT_DONE: begin
          if (!uart_busy_i) begin
            cnt <= '0;
            if (GAP_CYCLES == 0) begin
              grant_o <= idle_grant;
              state   <= UART_ARB_IDLE;
            end else begin
              state <= UART_ARB_GAP;
            end
          end
        end
        UART_ARB_GAP: begin
          if (cnt_nxt == CNT_W'(GAP_CYCLES)) begin
            grant_o <= idle_grant;
            state   <= UART_ARB_IDLE;
          end else begin
            cnt <= cnt_nxt;
          end
        end
        default: state <= UART_ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb: a 4-requester instance with
// a 2-clock gap and a 3-requester instance with no gap.
module tb_uart_tx_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [31:0] req_data_a = '0;
  logic [3:0]  req_last_a = '0;
  logic [3:0]  req_v_a    = '0;
  logic [3:0]  ack_a;
  logic [7:0]  tx_data_a;
  logic        tx_v_a;
  logic        busy_a     = 1'b0;
  logic [3:0]  grant_a;
  logic        arb_busy_a;
  logic        err_a;
  logic        clr_a      = 1'b0;

  logic [23:0] req_data_b = '0;
  logic [2:0]  req_last_b = '0;
  logic [2:0]  req_v_b    = '0;
  logic [2:0]  ack_b;
  logic [7:0]  tx_data_b;
  logic        tx_v_b;
  logic        busy_b     = 1'b0;
  logic [2:0]  grant_b;
  logic        arb_busy_b;
  logic        err_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_arb #(
    .N_REQ(4), .GAP_CYCLES(2), .BUSY_TIMEOUT(16)
  ) dut_a (
    .clk_i(clk), .rst_i(rst),
    .req_data_i(req_data_a), .req_last_i(req_last_a),
    .req_v_i(req_v_a), .req_ack_o(ack_a),
    .tx_data_o(tx_data_a), .tx_v_o(tx_v_a),
    .uart_busy_i(busy_a), .grant_o(grant_a),
    .busy_o(arb_busy_a), .err_timeout_o(err_a),
    .clr_err_i(clr_a)
  );

  uart_tx_arb #(
    .N_REQ(3), .GAP_CYCLES(0), .BUSY_TIMEOUT(16)
  ) dut_b (
    .clk_i(clk), .rst_i(rst),
    .req_data_i(req_data_b), .req_last_i(req_last_b),
    .req_v_i(req_v_b), .req_ack_o(ack_b),
    .tx_data_o(tx_data_b), .tx_v_o(tx_v_b),
    .uart_busy_i(busy_b), .grant_o(grant_b),
    .busy_o(arb_busy_b), .err_timeout_o(err_b),
    .clr_err_i(1'b0)
  );

  // transmitter model: busy rises dly clocks after tx_v, held len clocks
  int bm_dly_a = 2, bm_len_a = 10, bm_ph_a = 0, bm_c_a = 0;
  bit bm_en_a  = 1'b1;
  int bm_ph_b  = 0, bm_c_b = 0;

  always @(negedge clk) begin
    if (bm_ph_a == 0) begin
      if (tx_v_a && bm_en_a) begin bm_c_a = bm_dly_a; bm_ph_a = 1; end
    end else if (bm_ph_a == 1) begin
      bm_c_a = bm_c_a - 1;
      if (bm_c_a == 0) begin busy_a = 1'b1; bm_c_a = bm_len_a; bm_ph_a = 2; end
    end else begin
      bm_c_a = bm_c_a - 1;
      if (bm_c_a == 0) begin busy_a = 1'b0; bm_ph_a = 0; end
    end
  end

  always @(negedge clk) begin
    if (bm_ph_b == 0) begin
      if (tx_v_b) begin bm_c_b = 1; bm_ph_b = 1; end
    end else if (bm_ph_b == 1) begin
      bm_c_b = bm_c_b - 1;
      if (bm_c_b == 0) begin busy_b = 1'b1; bm_c_b = 2; bm_ph_b = 2; end
    end else begin
      bm_c_b = bm_c_b - 1;
      if (bm_c_b == 0) begin busy_b = 1'b0; bm_ph_b = 0; end
    end
  end

  logic [7:0] qd_a[$];
  logic [3:0] qg_a[$];
  logic [3:0] qk_a[$];
  logic [7:0] qd_b[$];
  logic [2:0] qg_b[$];
  int n_ack_a = 0, n_iss_a = 0, n_ack_b = 0, n_iss_b = 0;

  always @(negedge clk) begin
    n_ack_a = n_ack_a + $countones(ack_a);
    n_ack_b = n_ack_b + $countones(ack_b);
    if (tx_v_a) begin
      n_iss_a = n_iss_a + 1;
      qd_a.push_back(tx_data_a);
      qg_a.push_back(grant_a);
      qk_a.push_back(ack_a);
    end
    if (tx_v_b) begin
      n_iss_b = n_iss_b + 1;
      qd_b.push_back(tx_data_b);
      qg_b.push_back(grant_b);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drain_a();
    int n = 0;
    while (arb_busy_a && n < 200) begin tick(); n++; end
    checks++;
    if (arb_busy_a !== 1'b0) begin
      errors++; $display("FAIL drain_a: busy_o=%b want 0", arb_busy_a);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++; if (tx_v_a !== 1'b0) begin errors++; $display("FAIL rst_tx_v: got %b want 0", tx_v_a); end
    checks++; if (tx_data_a !== 8'h00) begin errors++; $display("FAIL rst_tx_data: got %h want 00", tx_data_a); end
    checks++; if (ack_a !== 4'h0) begin errors++; $display("FAIL rst_ack: got %b want 0000", ack_a); end
    checks++; if (grant_a !== 4'h0) begin errors++; $display("FAIL rst_grant: got %b want 0000", grant_a); end
    checks++; if (arb_busy_a !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", arb_busy_a); end
    checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", err_a); end
    checks++; if ({tx_v_b, grant_b, arb_busy_b, err_b} !== 6'h0) begin
      errors++; $display("FAIL rst_b: got %b want 000000", {tx_v_b, grant_b, arb_busy_b, err_b});
    end
    rst = 1'b0;
  endtask

  task automatic test_idle();
    bit ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (tx_v_a || ack_a != 0 || grant_a != 0 || arb_busy_a) ok = 1'b0;
    end
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL idle_stable: got %b want 1", ok); end
  endtask

  task automatic test_single();
    int n;
    bm_dly_a = 2; bm_len_a = 10;
    req_data_a[15:8] = 8'hA5; req_last_a[1] = 1'b1; req_v_a[1] = 1'b1;
    tick();
    checks++; if (tx_v_a !== 1'b1) begin errors++; $display("FAIL single_tx_v: got %b want 1", tx_v_a); end
    checks++; if (tx_data_a !== 8'hA5) begin errors++; $display("FAIL single_data: got %h want a5", tx_data_a); end
    checks++; if (ack_a !== 4'b0010) begin errors++; $display("FAIL single_ack: got %b want 0010", ack_a); end
    checks++; if (grant_a !== 4'b0010) begin errors++; $display("FAIL single_grant: got %b want 0010", grant_a); end
    req_v_a[1] = 1'b0;
    tick();
    checks++; if ({tx_v_a, ack_a} !== 5'b0) begin
      errors++; $display("FAIL single_pulse: got %b want 00000", {tx_v_a, ack_a});
    end
    n = 0;
    while (!busy_a && n < 20) begin tick(); n++; end
    n = 0;
    while (arb_busy_a && n < 40) begin tick(); n++; end
    checks++; if (n != 13) begin errors++; $display("FAIL single_busy_len: got %0d want 13", n); end
    checks++; if (grant_a !== 4'b0000) begin errors++; $display("FAIL single_grant_idle: got %b want 0000", grant_a); end
  endtask

  task automatic test_rotation();
    int base, n, k;
    rst = 1'b1; tick(); rst = 1'b0;
    bm_dly_a = 1; bm_len_a = 3;
    base = qd_a.size();
    for (int i = 0; i < 4; i++) req_data_a[i*8 +: 8] = 8'(8'h40 + i);
    req_last_a = 4'hF; req_v_a = 4'hF;
    n = 0;
    while (qd_a.size() < base + 6 && n < 400) begin tick(); n++; end
    req_v_a = 4'h0;
    checks++;
    if (qd_a.size() < base + 6) begin
      errors++; $display("FAIL rot_count: got %0d want 6", qd_a.size() - base);
    end else begin
      for (int i = 0; i < 6; i++) begin
        k = i % 4;
        checks++;
        if (qd_a[base+i] !== 8'(8'h40 + k)) begin
          errors++; $display("FAIL rot_data[%0d]: got %h want %h", i, qd_a[base+i], 8'(8'h40 + k));
        end
        checks++;
        if (qk_a[base+i] !== 4'(1 << k) || qg_a[base+i] !== 4'(1 << k)) begin
          errors++; $display("FAIL rot_ack[%0d]: got ack %b grant %b want %b", i, qk_a[base+i], qg_a[base+i], 4'(1 << k));
        end
      end
    end
    drain_a();
  endtask

  task automatic test_lock();
    logic [7:0] pkt[3];
    int  base, n;
    bit  in_pkt = 1'b0, gok = 1'b1;
    logic [7:0] exp_d[4];
    logic [3:0] exp_g[4];
    pkt[0] = 8'h11; pkt[1] = 8'h22; pkt[2] = 8'h33;
    exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33; exp_d[3] = 8'h99;
    exp_g[0] = 4'b0100; exp_g[1] = 4'b0100; exp_g[2] = 4'b0100; exp_g[3] = 4'b0001;
    bm_dly_a = 1; bm_len_a = 2;
    base = qd_a.size();
    for (int b = 0; b < 3; b++) begin
      req_data_a[23:16] = pkt[b];
      req_last_a[2] = (b == 2);
      req_v_a[2] = 1'b1;
      n = 0;
      tick();
      if (in_pkt && grant_a !== 4'b0100) gok = 1'b0;
      while (ack_a[2] !== 1'b1 && n < 100) begin
        tick(); n++;
        if (in_pkt && grant_a !== 4'b0100) gok = 1'b0;
      end
      if (b == 0) begin
        in_pkt = 1'b1;
        req_data_a[7:0] = 8'h99; req_last_a[0] = 1'b1; req_v_a[0] = 1'b1;
      end
    end
    req_v_a[2] = 1'b0;
    n = 0;
    tick();
    while (ack_a[0] !== 1'b1 && n < 100) begin tick(); n++; end
    req_v_a[0] = 1'b0;
    checks++;
    if (gok !== 1'b1) begin errors++; $display("FAIL lock_grant: got %b want 1", gok); end
    checks++;
    if (qd_a.size() < base + 4) begin
      errors++; $display("FAIL lock_count: got %0d want 4", qd_a.size() - base);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (qd_a[base+i] !== exp_d[i] || qg_a[base+i] !== exp_g[i]) begin
          errors++; $display("FAIL lock_seq[%0d]: got %h/%b want %h/%b", i, qd_a[base+i], qg_a[base+i], exp_d[i], exp_g[i]);
        end
      end
    end
    drain_a();
  endtask

  task automatic test_timeout();
    int n;
    bm_en_a = 1'b0;
    req_data_a[31:24] = 8'h5A; req_last_a[3] = 1'b0; req_v_a[3] = 1'b1;
    n = 0;
    tick();
    while (ack_a[3] !== 1'b1 && n < 100) begin tick(); n++; end
    req_v_a[3] = 1'b0;
    repeat (16) tick();
    checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL to_early: got %b want 0", err_a); end
    tick();
    checks++; if (err_a !== 1'b1) begin errors++; $display("FAIL to_set: got %b want 1", err_a); end
    checks++; if ({arb_busy_a, grant_a} !== 5'b0) begin
      errors++; $display("FAIL to_idle_unlock: got %b want 00000", {arb_busy_a, grant_a});
    end
    clr_a = 1'b1; tick(); clr_a = 1'b0;
    checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL to_clr: got %b want 0", err_a); end
    req_data_a[7:0] = 8'h3C; req_last_a[0] = 1'b1; req_v_a[0] = 1'b1;
    n = 0;
    tick();
    while (ack_a[0] !== 1'b1 && n < 100) begin tick(); n++; end
    req_v_a[0] = 1'b0;
    checks++; if (tx_data_a !== 8'h3C) begin errors++; $display("FAIL to_next_owner: got %h want 3c", tx_data_a); end
    repeat (16) tick();
    clr_a = 1'b1; tick(); clr_a = 1'b0;
    checks++; if (err_a !== 1'b1) begin errors++; $display("FAIL to_set_wins: got %b want 1", err_a); end
    clr_a = 1'b1; tick(); clr_a = 1'b0;
    checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL to_clr2: got %b want 0", err_a); end
    bm_en_a = 1'b1;
  endtask

  task automatic test_reset_mid();
    int n;
    bm_dly_a = 1; bm_len_a = 20;
    req_data_a[23:16] = 8'h77; req_last_a[2] = 1'b0; req_v_a[2] = 1'b1;
    n = 0;
    tick();
    while (ack_a[2] !== 1'b1 && n < 100) begin tick(); n++; end
    req_v_a[2] = 1'b0;
    n = 0;
    while (!busy_a && n < 20) begin tick(); n++; end
    repeat (3) tick();
    checks++; if (arb_busy_a !== 1'b1) begin errors++; $display("FAIL mid_in_frame: got %b want 1", arb_busy_a); end
    rst = 1'b1; tick();
    checks++;
    if ({tx_v_a, tx_data_a, ack_a, grant_a, arb_busy_a, err_a} !== 19'h0) begin
      errors++; $display("FAIL mid_rst_out: got %h want 0", {tx_v_a, tx_data_a, ack_a, grant_a, arb_busy_a, err_a});
    end
    rst = 1'b0;
    n = 0;
    while (busy_a && n < 40) begin tick(); n++; end
    req_data_a = 32'hCC88_0044; req_last_a = 4'hF; req_v_a = 4'b1101;
    n = 0;
    tick();
    while (tx_v_a !== 1'b1 && n < 100) begin tick(); n++; end
    req_v_a = 4'h0;
    checks++;
    if (tx_data_a !== 8'h44 || grant_a !== 4'b0001) begin
      errors++; $display("FAIL mid_first_win: got %h/%b want 44/0001", tx_data_a, grant_a);
    end
    drain_a();
  endtask

  task automatic test_gap0();
    int  base, n;
    bit  prev = 1'b0, chk_next = 1'b0, done_fall = 1'b0;
    logic [7:0] exp_d[4];
    logic [2:0] exp_g[4];
    exp_d[0] = 8'h30; exp_d[1] = 8'h31; exp_d[2] = 8'h32; exp_d[3] = 8'h30;
    exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b100; exp_g[3] = 3'b001;
    base = qd_b.size();
    req_data_b = 24'h32_31_30; req_last_b = 3'b111; req_v_b = 3'b111;
    n = 0;
    while (qd_b.size() < base + 4 && n < 300) begin
      tick(); n++;
      if (chk_next) begin
        checks++;
        if (arb_busy_b !== 1'b0) begin errors++; $display("FAIL gap0_idle: got %b want 0", arb_busy_b); end
        chk_next = 1'b0; done_fall = 1'b1;
      end
      if (!done_fall && prev && !busy_b) chk_next = 1'b1;
      prev = busy_b;
    end
    req_v_b = 3'b000;
    checks++; if (done_fall !== 1'b1) begin errors++; $display("FAIL gap0_fall_seen: got %b want 1", done_fall); end
    checks++;
    if (qd_b.size() < base + 4) begin
      errors++; $display("FAIL gap0_count: got %0d want 4", qd_b.size() - base);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (qd_b[base+i] !== exp_d[i] || qg_b[base+i] !== exp_g[i]) begin
          errors++; $display("FAIL gap0_seq[%0d]: got %h/%b want %h/%b", i, qd_b[base+i], qg_b[base+i], exp_d[i], exp_g[i]);
        end
      end
    end
    n = 0;
    while (arb_busy_b && n < 100) begin tick(); n++; end
  endtask

  task automatic test_ack_count();
    checks++;
    if (n_ack_a != n_iss_a) begin errors++; $display("FAIL ack_count_a: got %0d want %0d", n_ack_a, n_iss_a); end
    checks++;
    if (n_ack_b != n_iss_b) begin errors++; $display("FAIL ack_count_b: got %0d want %0d", n_ack_b, n_iss_b); end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_idle();
    test_single();
    test_rotation();
    test_lock();
    test_timeout();
    test_reset_mid();
    test_gap0();
    test_ack_count();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
